// File: rtl/core_switch_ctrl.sv
// core_switch_ctrl: dual-core master selection with dwell-limited failover,
// operator force commands and switch event reporting.
module core_switch_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1474560,
  parameter bit          PREFER_B    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alive_a,
  input  logic       alive_b,
  input  logic       force_valid,
  input  logic       force_sel,
  output logic       sel,
  output logic       both_dead,
  output logic       switch_pulse,
  output logic [7:0] switch_count,
  output logic       force_ack,
  output logic       force_nak
);
  typedef enum logic [1:0] {S_A, S_B, S_NONE} state_t;
  state_t      r_state;
  logic        r_sel, r_dead, r_pulse, r_ack, r_nak;
  logic [7:0]  r_cnt;
  logic [31:0] r_hold;
  logic        w_own, w_oth, w_hold_ok, w_nsel, w_none, w_ack, w_nak, w_sw;
  assign w_hold_ok = (r_hold == 32'd0);
  assign w_sw      = (w_nsel != r_sel);
  // own/other are the current master's and standby's alive levels
  always_comb begin
    w_own  = r_sel ? alive_b : alive_a;
    w_oth  = r_sel ? alive_a : alive_b;
    w_nsel = r_sel;
    w_none = (r_state == S_NONE);
    w_ack  = 1'b0;
    w_nak  = 1'b0;
    if (r_state == S_NONE) begin
      w_nak = force_valid;
      if (alive_a || alive_b) begin
        w_none = 1'b0;
        w_nsel = (alive_a && alive_b) ? PREFER_B : alive_b;
      end
    end else if (!w_own && !w_oth) begin
      w_none = 1'b1;
      w_nak  = force_valid;
    end else if (!w_own && w_hold_ok) begin
      w_nsel = !r_sel;
      w_ack  = force_valid && (force_sel == !r_sel);
      w_nak  = force_valid && (force_sel == r_sel);
    end else if (force_valid) begin
      // a force may override the dwell but never selects a dead core
      w_ack  = (force_sel == r_sel) || w_oth;
      w_nak  = !w_ack;
      w_nsel = w_ack ? force_sel : r_sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_sel   <= 1'b0;
      r_dead  <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= 8'd0;
      r_ack   <= 1'b0;
      r_nak   <= 1'b0;
      r_hold  <= 32'd0;
    end else begin
      r_state <= w_none ? S_NONE : (w_nsel ? S_B : S_A);
      r_sel   <= w_nsel;
      r_dead  <= w_none;
      r_pulse <= w_sw;
      r_cnt   <= (w_sw && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
      r_ack   <= w_ack;
      r_nak   <= w_nak;
      r_hold  <= w_sw ? 32'(HOLD_CYCLES) : (w_hold_ok ? r_hold : r_hold - 32'd1);
    end
  end
  assign sel          = r_sel;
  assign both_dead    = r_dead;
  assign switch_pulse = r_pulse;
  assign switch_count = r_cnt;
  assign force_ack    = r_ack;
  assign force_nak    = r_nak;
endmodule

// File: tb/tb_core_switch_ctrl.sv
// tb_core_switch_ctrl: randomized and directed check of core_switch_ctrl
// against a cycle-level reference model, with both PREFER_B settings.
module tb_core_switch_ctrl;
  localparam int HOLD = 16;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       alive_a = 1'b1, alive_b = 1'b1, fv = 1'b0, fs = 1'b0;
  logic [1:0] sel, dead, pulse, ack, nak;
  logic [7:0] cnt0, cnt1;
  bit         m_sel[2], m_dead[2], m_pulse[2], m_ack[2], m_nak[2];
  int         m_cnt[2], m_since[2];
  int         n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  core_switch_ctrl #(.HOLD_CYCLES(HOLD), .PREFER_B(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .alive_a(alive_a), .alive_b(alive_b),
    .force_valid(fv), .force_sel(fs), .sel(sel[0]), .both_dead(dead[0]),
    .switch_pulse(pulse[0]), .switch_count(cnt0), .force_ack(ack[0]), .force_nak(nak[0]));
  core_switch_ctrl #(.HOLD_CYCLES(HOLD), .PREFER_B(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .alive_a(alive_a), .alive_b(alive_b),
    .force_valid(fv), .force_sel(fs), .sel(sel[1]), .both_dead(dead[1]),
    .switch_pulse(pulse[1]), .switch_count(cnt1), .force_ack(ack[1]), .force_nak(nak[1]));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit alive_of(input bit c);
    return c ? alive_b : alive_a;
  endfunction
  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_sel[p] = 0; m_dead[p] = 0; m_pulse[p] = 0; m_ack[p] = 0; m_nak[p] = 0;
      m_cnt[p] = 0; m_since[p] = HOLD;
    end
  endtask
  // m_since counts edges since the last sel change; dwell is over once it reaches HOLD
  task automatic model_step(input int p);
    bit nsel, ndead, a, k;
    nsel = m_sel[p]; ndead = m_dead[p]; a = 0; k = 0;
    if (m_dead[p]) begin
      k = fv;
      if (alive_a || alive_b) begin
        ndead = 0;
        nsel = (alive_a && alive_b) ? (p == 1) : alive_b;
      end
    end else if (!alive_a && !alive_b) begin
      ndead = 1; k = fv;
    end else if (!alive_of(m_sel[p]) && m_since[p] >= HOLD) begin
      nsel = !m_sel[p]; a = fv && (fs == nsel); k = fv && (fs != nsel);
    end else if (fv) begin
      if (fs == m_sel[p] || alive_of(fs)) begin a = 1; nsel = fs; end
      else k = 1;
    end
    m_pulse[p] = (nsel != m_sel[p]);
    m_cnt[p]   = (m_cnt[p] + int'(m_pulse[p]) > 255) ? 255 : m_cnt[p] + int'(m_pulse[p]);
    m_since[p] = m_pulse[p] ? 0 : (m_since[p] < 1000 ? m_since[p] + 1 : m_since[p]);
    m_sel[p] = nsel; m_dead[p] = ndead; m_ack[p] = a; m_nak[p] = k;
  endtask
  task automatic compare_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("sel[%0d]", p), sel[p], m_sel[p]);
      chk($sformatf("both_dead[%0d]", p), dead[p], m_dead[p]);
      chk($sformatf("switch_pulse[%0d]", p), pulse[p], m_pulse[p]);
      chk($sformatf("switch_count[%0d]", p), p ? cnt1 : cnt0, m_cnt[p]);
      chk($sformatf("force_ack[%0d]", p), ack[p], m_ack[p]);
      chk($sformatf("force_nak[%0d]", p), nak[p], m_nak[p]);
    end
  endtask
  task automatic cyc(input bit a, input bit b, input bit v, input bit s);
    alive_a = a; alive_b = b; fv = v; fs = s;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    fv = 0;
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_sel", sel[0], 0);
    chk("rst_dead", dead[0], 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_ack_nak", {ack[0], nak[0], pulse[0]}, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    bit a, b, pv, v;
    @(negedge clk);
    do_reset();
    repeat (9) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("fail_sel", sel[0], 1); chk("fail_pulse", pulse[0], 1); chk("fail_cnt", cnt0, 1);
    cyc(0, 1, 0, 0);
    repeat (15) begin
      cyc(1, 0, 0, 0);
      chk("dwell_sel", sel[0], 1);
    end
    cyc(1, 0, 0, 0);
    chk("dwell_end_sel", sel[0], 0); chk("dwell_end_cnt", cnt0, 2);
    cyc(1, 1, 1, 1);
    chk("force_dwell_sel", sel[0], 1); chk("force_dwell_ack", ack[0], 1);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("force_dead_nak", nak[0], 1); chk("force_dead_sel", sel[0], 1);
    cyc(0, 0, 0, 0);
    chk("none_dead", dead[0], 1); chk("none_sel", sel[0], 1);
    cyc(1, 1, 0, 0);
    chk("pref_a_sel", sel[0], 0); chk("pref_a_pulse", pulse[0], 1);
    chk("pref_b_sel", sel[1], 1); chk("pref_b_pulse", pulse[1], 0);
    repeat (17) cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("coinc_nak_sel", sel[0], 1); chk("coinc_nak", nak[0], 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    chk("force_a_sel", sel[0], 0);
    repeat (17) cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 1);
    chk("coinc_ack_sel", sel[0], 1); chk("coinc_ack", ack[0], 1);
    cyc(1, 1, 0, 0);
    repeat (300) begin
      cyc(1, 1, 1, !sel[0]);
      cyc(1, 1, 0, 0);
    end
    chk("sat_cnt", cnt0, 255);
    cyc(1, 1, 1, !sel[0]);
    do_reset();
    a = 1; b = 1; pv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) a = !a;
      if ($urandom_range(0, 19) == 0) b = !b;
      v = !pv && ($urandom_range(0, 4) == 0);
      pv = v;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        pv = 0;
      end else cyc(a, b, v, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
